// File: rtl/jesd204b_pkg.sv
// Shared JESD204B definitions: control-character octets used by the link
// layer and this encoder, running-disparity encoding, and the 8b/10b
// sub-block tables.
// Sub-block codes are held in abcdei / fghj order, with 'a' (or 'f') as the MSB.
// bitrev10 turns {abcdei, fghj} into wire order, with bit 0 = 'a'.
package jesd204b_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [7:0] K28_0 = 8'h1C;   // R
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;   // A
    localparam logic [7:0] K28_4 = 8'h9C;   // Q
    localparam logic [7:0] K28_5 = 8'hBC;   // K
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;   // F
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    localparam logic [3:0] A7_NEG = 4'b0111;
    localparam logic [3:0] A7_POS = 4'b1000;

    typedef struct packed {
        logic [5:0] neg;
        logic [5:0] pos;
        logic       unbal;
    } sub6_t;

    typedef struct packed {
        logic [3:0] neg;
        logic [3:0] pos;
        logic       unbal;
    } sub4_t;

    function automatic logic k_is_legal(input logic [7:0] v);
        logic r;
        r = 1'b0;
        case (v)
            K28_0, K28_1, K28_2, K28_3, K28_4, K28_5, K28_6, K28_7,
            K23_7, K27_7, K29_7, K30_7: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Table entry is {unbalanced, RD- code}. The RD+ code is the complement
    // when unbalanced; D.7 (111000/000111) is balanced but still alternates.
    function automatic sub6_t enc_5b6b(input logic [4:0] edcba, input logic k);
        logic [6:0] t;
        sub6_t      r;
        case (edcba)
            5'd0:  t = 7'b1_100111;  5'd1:  t = 7'b1_011101;
            5'd2:  t = 7'b1_101101;  5'd3:  t = 7'b0_110001;
            5'd4:  t = 7'b1_110101;  5'd5:  t = 7'b0_101001;
            5'd6:  t = 7'b0_011001;  5'd7:  t = 7'b0_111000;
            5'd8:  t = 7'b1_111001;  5'd9:  t = 7'b0_100101;
            5'd10: t = 7'b0_010101;  5'd11: t = 7'b0_110100;
            5'd12: t = 7'b0_001101;  5'd13: t = 7'b0_101100;
            5'd14: t = 7'b0_011100;  5'd15: t = 7'b1_010111;
            5'd16: t = 7'b1_011011;  5'd17: t = 7'b0_100011;
            5'd18: t = 7'b0_010011;  5'd19: t = 7'b0_110010;
            5'd20: t = 7'b0_001011;  5'd21: t = 7'b0_101010;
            5'd22: t = 7'b0_011010;  5'd23: t = 7'b1_111010;
            5'd24: t = 7'b1_110011;  5'd25: t = 7'b0_100110;
            5'd26: t = 7'b0_010110;  5'd27: t = 7'b1_110110;
            5'd28: t = 7'b0_001110;  5'd29: t = 7'b1_101110;
            5'd30: t = 7'b1_011110;
            default: t = 7'b1_101011;
        endcase
        if (k && edcba == 5'd28) t = 7'b1_001111;
        r.neg   = t[5:0];
        r.unbal = t[6];
        r.pos   = (t[6] || edcba == 5'd7) ? ~t[5:0] : t[5:0];
        return r;
    endfunction

    // Data x.7 returns the primary P7 code; the A7 choice for data depends on
    // the 5b value and is made in the chain. K.x.7 always uses A7. For K codes
    // the RD- column is the complement of the RD+ column, including neutral codes.
    function automatic sub4_t enc_3b4b(input logic [2:0] hgf, input logic k);
        logic [4:0] t;
        sub4_t      r;
        case (hgf)
            3'd0: t = 5'b1_1011;  3'd1: t = 5'b0_1001;
            3'd2: t = 5'b0_0101;  3'd3: t = 5'b0_1100;
            3'd4: t = 5'b1_1101;  3'd5: t = 5'b0_1010;
            3'd6: t = 5'b0_0110;
            default: t = k ? {1'b1, A7_NEG} : 5'b1_1110;
        endcase
        r.unbal = t[4];
        r.pos   = (t[4] || hgf == 3'd3) ? ~t[3:0] : t[3:0];
        r.neg   = k ? ~r.pos : t[3:0];
        return r;
    endfunction

    function automatic logic [9:0] bitrev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

endpackage

// File: rtl/jesd204b_8b10b_octet_enc.sv
// Combinational 8b/10b encoder for one octet.
// Ports: octet/k = input character, rd_in = running disparity before it;
//        sym = 10-bit symbol (bit 0 = 'a'), rd_next = disparity after it,
//        k_illegal = k set on a non-control value (encoded as K28.5 instead).
module jesd204b_8b10b_octet_enc
    import jesd204b_pkg::*;
(
    input  logic [7:0] octet,
    input  logic       k,
    input  logic       rd_in,
    output logic [9:0] sym,
    output logic       rd_next,
    output logic       k_illegal
);

    logic [7:0] oct_eff;
    sub6_t      s6;
    sub4_t      s4;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd_mid;
    logic       use_a7;

    always_comb begin
        k_illegal = k && !k_is_legal(octet);
        oct_eff   = k_illegal ? K28_5 : octet;
        s6        = enc_5b6b(oct_eff[4:0], k);
        s4        = enc_3b4b(oct_eff[7:5], k);
        c6        = (rd_in == RD_POS) ? s6.pos : s6.neg;
        rd_mid    = s6.unbal ? ~rd_in : rd_in;
        // A7 avoids a run of five identical bits across the e-i / f-g boundary.
        use_a7    = !k && oct_eff[7:5] == 3'd7 &&
                    ((rd_mid == RD_NEG && (oct_eff[4:0] == 5'd17 || oct_eff[4:0] == 5'd18 ||
                                           oct_eff[4:0] == 5'd20)) ||
                     (rd_mid == RD_POS && (oct_eff[4:0] == 5'd11 || oct_eff[4:0] == 5'd13 ||
                                           oct_eff[4:0] == 5'd14)));
        if (use_a7) c4 = (rd_mid == RD_POS) ? A7_POS : A7_NEG;
        else        c4 = (rd_mid == RD_POS) ? s4.pos : s4.neg;
        rd_next   = s4.unbal ? ~rd_mid : rd_mid;
        sym       = bitrev10({c6, c4});
    end

endmodule

// File: rtl/jesd204b_8b10b_encoder_x4.sv
// Four-octet 8b/10b encoder for the JESD204B TX path.
// Ports: clk, reset_b (async, active low); tx_par_data/tx_datak = one word per
//        clock, with octet 0 first; enc_data = 4 symbols, [9:0] first;
//        enc_valid = pipeline filled; rd_out = disparity after the last symbol;
//        k_err = illegal K in this word; disp_err = sticky self-check failure.
// Stage 1 registers the word. Stage 2 chains four octet encoders from the rd
// register. With OUT_REG set, a final register stage follows.
module jesd204b_8b10b_encoder_x4
    import jesd204b_pkg::*;
#(
    parameter bit OUT_REG = 1'b1,
    parameter bit RD_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [31:0] tx_par_data,
    input  logic [3:0]  tx_datak,
    output logic [39:0] enc_data,
    output logic        enc_valid,
    output logic        rd_out,
    output logic        k_err,
    output logic        disp_err
);

    logic [31:0] s1_data;
    logic [3:0]  s1_k;
    logic        s1_valid;
    logic        rd_q;
    logic [4:0]  rd_chain;
    logic [39:0] s2_data;
    logic [3:0]  k_ill;
    logic        chk_bad;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1_data  <= '0;
            s1_k     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_data  <= tx_par_data;
            s1_k     <= tx_datak;
            s1_valid <= 1'b1;
        end
    end

    assign rd_chain[0] = rd_q;

    for (genvar i = 0; i < 4; i++) begin : g_oct
        jesd204b_8b10b_octet_enc u_enc (
            .octet     (s1_data[i*8 +: 8]),
            .k         (s1_k[i]),
            .rd_in     (rd_chain[i]),
            .sym       (s2_data[i*10 +: 10]),
            .rd_next   (rd_chain[i+1]),
            .k_illegal (k_ill[i])
        );
    end

    // Each symbol must carry 4/5/6 ones. Unbalanced symbols must oppose the
    // disparity they were sent from and flip it. Neutral symbols must leave it.
    always_comb begin
        chk_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case ($countones(s2_data[i*10 +: 10]))
                4: if (rd_chain[i] != RD_POS || rd_chain[i+1] != RD_NEG) chk_bad = 1'b1;
                5: if (rd_chain[i+1] != rd_chain[i]) chk_bad = 1'b1;
                6: if (rd_chain[i] != RD_NEG || rd_chain[i+1] != RD_POS) chk_bad = 1'b1;
                default: chk_bad = 1'b1;
            endcase
        end
    end

    // rd only advances on real words, so the cleared stage-1 contents after
    // reset never disturb RD_INIT.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_q     <= RD_INIT;
            disp_err <= 1'b0;
        end else if (s1_valid) begin
            rd_q <= rd_chain[4];
            if (chk_bad) disp_err <= 1'b1;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [39:0] data_q;
        logic        valid_q;
        logic        kerr_q;

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                kerr_q  <= 1'b0;
            end else begin
                data_q  <= s1_valid ? s2_data : '0;
                valid_q <= s1_valid;
                kerr_q  <= s1_valid & (|k_ill);
            end
        end

        assign enc_data  = data_q;
        assign enc_valid = valid_q;
        assign k_err     = kerr_q;
        // rd_q is loaded on the same edge as data_q, so they stay aligned.
        assign rd_out    = rd_q;
    end else begin : g_out_comb
        assign enc_data  = s1_valid ? s2_data : '0;
        assign enc_valid = s1_valid;
        assign k_err     = s1_valid & (|k_ill);
        assign rd_out    = s1_valid ? rd_chain[4] : rd_q;
    end

endmodule

// File: tb/tb_jesd204b_8b10b_encoder_x4.sv
module tb_jesd204b_8b10b_encoder_x4;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [31:0] tx_par_data;
    logic [3:0]  tx_datak;
    logic [39:0] enc_data;
    logic        enc_valid;
    logic        rd_out;
    logic        k_err;
    logic        disp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    jesd204b_8b10b_encoder_x4 #(.OUT_REG(1'b1), .RD_INIT(1'b0)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .tx_par_data (tx_par_data),
        .tx_datak    (tx_datak),
        .enc_data    (enc_data),
        .enc_valid   (enc_valid),
        .rd_out      (rd_out),
        .k_err       (k_err),
        .disp_err    (disp_err)
    );

    // Standard code tables in abcdei / fghj notation, RD- column only.
    logic [5:0] d6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [3:0] d4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [7:0] kcode [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};
    // Full K symbols from RD- as abcdeifghj; the RD+ form is the complement.
    logic [9:0] ksym [12] = '{10'b001111_0100, 10'b001111_1001, 10'b001111_0101, 10'b001111_0011,
                              10'b001111_0010, 10'b001111_1010, 10'b001111_0110, 10'b001111_1000,
                              10'b111010_1000, 10'b110110_1000, 10'b101110_1000, 10'b011110_1000};

    bit          m_rd;
    logic [39:0] q_data [$];
    logic        q_rd   [$];
    logic        q_kerr [$];

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    // Reference encoder: picks each sub-block from m_rd, then moves m_rd
    // by the sub-block's ones count, with the 000111/111000 and 0011/1100
    // cases setting it explicitly.
    task automatic model_octet(input logic [7:0] d, input logic k, output logic [9:0] sym,
                               output logic ill);
        logic [9:0] code;
        logic [5:0] c6;
        logic [3:0] c4;
        int         idx, n, x, y;
        ill = 1'b0;
        if (k) begin
            idx = -1;
            for (int i = 0; i < 12; i++) if (kcode[i] == d) idx = i;
            if (idx < 0) begin
                ill = 1'b1;
                idx = 5;
            end
            code = m_rd ? ~ksym[idx] : ksym[idx];
            n = $countones(code);
            if (n == 6) m_rd = 1'b1;
            else if (n == 4) m_rd = 1'b0;
        end else begin
            x  = int'(d[4:0]);
            y  = int'(d[7:5]);
            c6 = d6[x];
            if (m_rd && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
            n = $countones(c6);
            if (n > 3 || c6 == 6'b000111) m_rd = 1'b1;
            else if (n < 3 || c6 == 6'b111000) m_rd = 1'b0;
            if (y == 7 && ((!m_rd && (x == 17 || x == 18 || x == 20)) ||
                           (m_rd && (x == 11 || x == 13 || x == 14)))) c4 = 4'b0111;
            else c4 = d4[y];
            if (m_rd && ($countones(c4) != 2 || c4 == 4'b1100)) c4 = ~c4;
            n = $countones(c4);
            if (n > 2 || c4 == 4'b0011) m_rd = 1'b1;
            else if (n < 2 || c4 == 4'b1100) m_rd = 1'b0;
            code = {c6, c4};
        end
        sym = rev10(code);
    endtask

    // Called at a falling edge: check the word sent two clocks earlier, then
    // apply the new word and queue the model's result for it.
    task automatic drive_word(input logic [31:0] d, input logic [3:0] k);
        logic [39:0] e_sym;
        logic [9:0]  s;
        logic        ill, e_kerr;
        if (q_data.size() == 2) begin
            check("enc_valid", enc_valid, 40'd1);
            check("enc_data", enc_data, q_data.pop_front());
            check("rd_out", rd_out, q_rd.pop_front());
            check("k_err", k_err, q_kerr.pop_front());
            check("disp_err", disp_err, 40'd0);
        end else begin
            check("enc_valid_fill", enc_valid, 40'd0);
        end
        tx_par_data = d;
        tx_datak    = k;
        e_kerr      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_octet(d[i*8 +: 8], k[i], s, ill);
            e_sym[i*10 +: 10] = s;
            e_kerr |= ill;
        end
        q_data.push_back(e_sym);
        q_rd.push_back(m_rd);
        q_kerr.push_back(e_kerr);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q_data.delete();
        q_rd.delete();
        q_kerr.delete();
        m_rd = 1'b0;
    endtask

    function automatic logic [7:0] rand_legal_k();
        return kcode[$urandom_range(0, 11)];
    endfunction

    initial begin
        logic [31:0] w;
        logic [3:0]  kf;
        reset_b     = 1'b0;
        tx_par_data = '0;
        tx_datak    = '0;
        model_reset();
        #1;
        check("rst_enc_data", enc_data, 40'd0);
        check("rst_enc_valid", enc_valid, 40'd0);
        check("rst_k_err", k_err, 40'd0);
        check("rst_disp_err", disp_err, 40'd0);
        check("rst_rd_out", rd_out, 40'd0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;

        // CGS
        repeat (4) drive_word(32'hBCBCBCBC, 4'hF);
        check("cgs_word", enc_data, {10'h283, 10'h17C, 10'h283, 10'h17C});
        check("cgs_rd", rd_out, 40'd0);

        // Neutral data
        repeat (3) drive_word(32'hB5B5B5B5, 4'h0);
        check("d21_5_word", enc_data, {4{10'h155}});
        check("d21_5_rd", rd_out, 40'd0);
        repeat (3) drive_word(32'h00000000, 4'h0);
        check("d0_0_word", enc_data, {4{10'h0B9}});

        // Disparity carried across octets and cycles
        drive_word(32'h000000BC, 4'h1);
        drive_word(32'h00000000, 4'h0);
        check("k28_5_carry", enc_data, {10'h346, 10'h346, 10'h346, 10'h17C});
        check("k28_5_carry_rd", rd_out, 40'd1);
        drive_word(32'h00000000, 4'h0);
        check("next_cycle_rdpos", enc_data, {4{10'h346}});

        // Illegal K in octet 0 (running disparity is RD+ here)
        drive_word(32'h1C1C1C05, 4'hF);
        drive_word(32'hBCBCBCBC, 4'hF);
        check("illegal_k_kerr", k_err, 40'd1);
        check("illegal_k_sub", enc_data[9:0], 40'h283);
        drive_word(32'hBCBCBCBC, 4'hF);
        check("illegal_k_clear", k_err, 40'd0);
        // Several illegal octets in one word
        drive_word(32'h00FF4105, 4'h7);
        repeat (2) drive_word(32'h1C1C1C1C, 4'hF);

        // A7 cases, from both disparities
        drive_word(32'hF1F1EBEB, 4'h0);
        drive_word(32'h000000BC, 4'h1);
        drive_word(32'hF1F1EBEB, 4'h0);
        drive_word(32'hEBF1F2F4, 4'h0);
        drive_word(32'hEDEEF1F2, 4'h0);

        // ILAS: 4 multiframes x 16 words, then user data
        for (int mf = 0; mf < 4; mf++) begin
            for (int wd = 0; wd < 16; wd++) begin
                w  = $urandom;
                kf = 4'h0;
                if (wd == 0) begin
                    w[7:0] = 8'h1C;
                    kf[0]  = 1'b1;
                end
                if (mf == 1 && wd == 1) begin
                    w[7:0] = 8'h9C;
                    kf[0]  = 1'b1;
                end
                if (wd == 15) begin
                    w[31:24] = 8'h7C;
                    kf[3]    = 1'b1;
                end
                drive_word(w, kf);
            end
        end

        // Random user data with a mix of legal and illegal K
        for (int n = 0; n < 300; n++) begin
            w  = $urandom;
            kf = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++)
                if (kf[i] && $urandom_range(0, 9) < 8) w[i*8 +: 8] = rand_legal_k();
            drive_word(w, kf);
        end

        // Reset mid-stream
        drive_word(32'hF1F1EBEB, 4'h0);
        drive_word(32'h000000BC, 4'h1);
        @(posedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        check("midrst_enc_data", enc_data, 40'd0);
        check("midrst_enc_valid", enc_valid, 40'd0);
        check("midrst_k_err", k_err, 40'd0);
        check("midrst_rd_out", rd_out, 40'd0);
        @(negedge clk);
        reset_b = 1'b1;
        model_reset();
        drive_word(32'h000000BC, 4'h1);
        drive_word(32'h00000000, 4'h0);
        check("post_rst_word", enc_data, {10'h346, 10'h346, 10'h346, 10'h17C});
        for (int n = 0; n < 40; n++) drive_word($urandom, 4'h0);
        repeat (3) drive_word(32'h1C1C1C1C, 4'hF);
        check("final_disp_err", disp_err, 40'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jesd204b_8b10b_encoder_x4.md
Name: jesd204b_8b10b_encoder_x4

Overview:
- Downstream neighbour of the JESD204B TX link layer. Consumes its 4-octet word per clock (tx_par_data / tx_datak, octet 0 in bits [7:0] is transmitted first).
- Produces four 8b/10b symbols per clock with a running-disparity chain carried across octets and across cycles.
- Output feeds a transceiver configured in raw 40-bit mode, with its internal 8b/10b bypassed.

Parameters:
- OUT_REG, 1, 1 = register the 40-bit symbol output (latency 2); 0 = stage-2 output taken combinationally (latency 1).
- RD_INIT, 0, running disparity after reset: 0 = RD-, 1 = RD+.

Ports:
- clk  input  1  link clock (same clock as the link layer)
- reset_b  input  1  asynchronous active-low reset
- tx_par_data  input  32  octets; [7:0] first in time, [31:24] last
- tx_datak  input  4  K flag per octet; bit n qualifies octet n
- enc_data  output  40  symbols; [9:0] first; inside each symbol, bit 0 = 'a', bit 9 = 'j' (abcdei fghj, LSB first on the wire)
- enc_valid  output  1  pipeline filled, output meaningful
- rd_out  output  1  running disparity after the last symbol of the current enc_data word (1 = RD+)
- k_err  output  1  one-cycle pulse, aligned with enc_data: an octet in this word had K=1 with an illegal K value
- disp_err  output  1  sticky; internal self-check saw a symbol disparity outside {-2,0,+2} or a chain violation; cleared only by reset

Behaviour:
- Reset (asynchronous, reset_b=0):
  - enc_data = 40'h0, enc_valid = 0, k_err = 0, disp_err = 0.
  - rd register = RD_INIT; rd_out = RD_INIT.
  - All pipeline registers cleared.
- Stage 1 (registered), per octet, independently:
  - 5b/6b lookup on EDCBA and 3b/4b lookup on HGF, computed for both RD- and RD+.
  - Per sub-block flags: disparity-neutral, and "flip" when the sub-block is unbalanced.
  - K validity check: legal K values are 1C,3C,5C,7C,9C,BC,DC,FC (K28.0-K28.7), F7, FB, FD, FE (K23.7, K27.7, K29.7, K30.7).
  - An illegal K value is replaced by K28.5 (BC, K=1) and flagged for k_err.
- Stage 2, disparity chain:
  - Runs serially across octets 0→3 in one combinational chain, starting from the rd register.
  - Each sub-block selects its RD-/RD+ variant using the running disparity in effect at that point.
  - D.x.7 alternate A7 (0111/1000) is used when RD- and x ∈ {17,18,20}, or RD+ and x ∈ {11,13,14}; K.x.7 always uses A7.
  - D.x.3 and D.x.7 secondary-block selection follows IEEE 802.3 Clause 36 tables exactly.
  - The rd register is updated to the disparity after octet 3, every cycle.
- Latency: input to enc_data is 2 clocks with OUT_REG=1, 1 clock with OUT_REG=0. k_err is delayed to stay aligned with enc_data.
- enc_valid:
  - Goes to 1 once the pipeline is filled after reset release: 2 rising edges with OUT_REG=1, 1 with OUT_REG=0.
  - Stays 1 until the next reset.
- The input is accepted every cycle; there is no stall or backpressure. The link layer drives K28.0 while idle, so the chain is always exercised.
- Self-check: every emitted symbol must have 4, 5 or 6 ones. A symbol with 4 ones (or 6) must have been emitted from RD+ (or RD-). Any violation sets disp_err.
- Simultaneous events:
  - Illegal K in several octets of one word: each is substituted, with a single k_err pulse.
  - Reset mid-word: the partial word is discarded, rd restarts at RD_INIT, and the first post-reset symbols are encoded from RD_INIT.

Decomposition:
- Shared package jesd204b_pkg holds:
  - K-code constants (K28_0 … K28_7, K23_7, K27_7, K29_7, K30_7), shared with the link layer's R/A/F/K/Q codes.
  - The RD_NEG/RD_POS encoding.
  - The 5b/6b and 3b/4b table functions, returning both disparity variants and an unbalanced flag.
- One natural sub-module: jesd204b_8b10b_octet_enc. It is pure combinational, with inputs octet, k and rd_in and outputs sym[9:0], rd_next and k_illegal. The top instantiates four in a chain, plus the pipeline registers, rd register, valid logic and self-check.

Test Plan:
- CGS word: reset with RD_INIT=0, then tx_par_data=32'hBCBCBCBC, tx_datak=4'hF held → enc_data = {10'h283,10'h17C,10'h283,10'h17C} every cycle; rd_out=0; enc_valid=1 from the 2nd clock after reset release; k_err=0.
- Neutral data: RD-, 32'hB5B5B5B5, datak=0 → each symbol 10'h155 (D21.5); rd_out stays 0. Then 32'h00000000 → each symbol 10'h0B9 (D0.0 RD-); rd_out=0.
- Disparity carry across cycles: single K28.5 in octet 0 (32'h000000BC, datak=4'h1) from RD- → octet 0 = 10'h17C, octets 1-3 encoded from RD+ (D0.0 RD+ = 10'h346). rd_out=1, and the next cycle's octet 0 starts from RD+.
- Illegal K: tx_par_data=32'h1C1C1C05, datak=4'hF → octet 0 is emitted as K28.5; k_err=1 for exactly the cycle that word appears on enc_data; the following valid-K words give k_err=0.
- ILAS multiframe: drive a full 4×16-word ILAS plus user data, decode with a reference 8b/10b model → all octets and K flags round-trip, disp_err=0. Include the D.x.7 A7 cases 32'hF1F1EBEB.
- Reset mid-stream: assert reset_b=0 for one cycle during user data → enc_data, enc_valid and k_err go to 0 immediately (asynchronously); after release, the first word is encoded from RD_INIT, and enc_valid returns after 2 clocks.
